mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller: arbitrates instruction fetches and load/stores
// onto an 8-bit memory port, with stall, flush and I/O back-pressure handling.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_valid,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req_valid,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q, nbytes_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic        if_done_q, ls_done_q;

  logic [31:0] cur_addr, prev_addr, last_addr;
  logic [7:0]  wbyte;
  logic        io_block;

  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign cur_addr  = addr_q + {29'd0, cnt_q};
  assign prev_addr = cur_addr - 32'd1;
  assign last_addr = addr_q + {29'd0, nbytes_q} - 32'd1;
  assign io_block  = (state_q == LS_WR) && (cur_addr >= IO_BASE) && io_buffer_full;

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    case (state_q)
      IF_RD, LS_RD: begin
        // While stalled, re-present the byte whose data is still owed to us
        if (!rdy_in && cnt_q != 3'd0) mem_a = prev_addr;
        else if (cnt_q >= nbytes_q)   mem_a = last_addr;
        else                          mem_a = cur_addr;
      end
      LS_WR: begin
        mem_a    = cur_addr;
        mem_dout = wbyte;
        mem_wr   = rdy_in && !io_block;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      nbytes_q  <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      data_q    <= 32'd0;
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
    end else if (rdy_in) begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!if_done_q && !ls_done_q) begin
            if (ls_req_valid) begin
              state_q  <= ls_wr ? LS_WR : LS_RD;
              addr_q   <= ls_addr;
              nbytes_q <= size_to_n(ls_size);
              wdata_q  <= ls_wdata;
              data_q   <= 32'd0;
              cnt_q    <= 3'd0;
            end else if (if_req_valid && !if_flush) begin
              state_q  <= IF_RD;
              addr_q   <= if_addr;
              nbytes_q <= 3'd4;
              data_q   <= 32'd0;
              cnt_q    <= 3'd0;
            end
          end
        end
        IF_RD, LS_RD: begin
          if (state_q == IF_RD && if_flush) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
          end else begin
            for (int b = 0; b < 4; b++)
              if (cnt_q == 3'(b + 1)) data_q[8*b +: 8] <= mem_din;
            if (cnt_q == nbytes_q) begin
              state_q <= IDLE;
              cnt_q   <= 3'd0;
              if (state_q == IF_RD) if_done_q <= 1'b1;
              else                  ls_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        LS_WR: begin
          if (!io_block) begin
            if (cnt_q == nbytes_q - 3'd1) begin
              state_q   <= IDLE;
              cnt_q     <= 3'd0;
              ls_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_done  = if_done_q;
  assign ls_done  = ls_done_q;
  assign if_data  = data_q;
  assign ls_rdata = data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req_valid, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req_valid, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:4095];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) mem_din <= ram[mem_a[11:0]];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req_valid(ls_req_valid), .ls_wr(ls_wr), .ls_size(ls_size),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // Inputs change at posedge+2, outputs are sampled at posedge+3.
  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    if_req_valid = 1'b1;
    if_addr = 32'h100;
    repeat (2) cyc();
    #1;
    n_chk++;
    if ({if_done, ls_done, mem_wr, mem_dout, mem_a, if_data, ls_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b/%b wr=%b dout=%h a=%h ifd=%h lsd=%h, expected all zero",
               if_done, ls_done, mem_wr, mem_dout, mem_a, if_data, ls_rdata);
    end
    if_req_valid = 1'b0;
    rst_in = 1'b1;
  endtask

  task automatic test_if_read();
    int done_k = -1, ndone = 0;
    logic [31:0] got = '0;
    logic bad = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h100; #1;
    n_chk++;
    if (mem_a !== 32'd0 || mem_wr !== 1'b0) begin
      n_fail++; $display("FAIL idle_outputs: got a=%h wr=%b, expected 0/0", mem_a, mem_wr);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(); if_req_valid = 1'b0; #1;
      if (k <= 4 && mem_a !== 32'h100 + 32'(k - 1)) bad = 1'b1;
      if (k == 5 && mem_a !== 32'h103) bad = 1'b1;
      if (mem_wr !== 1'b0) bad = 1'b1;
      if (if_done === 1'b1) begin
        ndone++;
        if (done_k < 0) begin done_k = k; got = if_data; end
      end
    end
    n_chk++; if (bad) begin n_fail++; $display("FAIL if_addr_seq: got bad=%b, expected 0x100..0x103 no writes", bad); end
    n_chk++; if (done_k != 6) begin n_fail++; $display("FAIL if_latency: got cycle %0d, expected 6", done_k); end
    n_chk++; if (ndone != 1) begin n_fail++; $display("FAIL if_done_pulse: got %0d pulses, expected 1", ndone); end
    n_chk++; if (got !== 32'h0000_0513) begin n_fail++; $display("FAIL if_data: got %h, expected 00000513", got); end
  endtask

  task automatic test_arbitration();
    int lsd_k = -1, ifd_k = -1, first_if = -1, nls = 0, nif = 0;
    logic [31:0] lsdata = '0, ifdata = '0;
    ls_req_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
    if_req_valid = 1'b1; if_addr = 32'h200; #1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 1) ls_req_valid = 1'b0;
      if (lsd_k >= 0 && k == lsd_k + 2) if_req_valid = 1'b0;
      #1;
      if (ls_done === 1'b1) begin
        nls++;
        if (lsd_k < 0) begin lsd_k = k; lsdata = ls_rdata; end
      end
      if (mem_a === 32'h200 && first_if < 0) first_if = k;
      if (if_done === 1'b1) begin
        nif++;
        if (ifd_k < 0) begin ifd_k = k; ifdata = if_data; end
      end
    end
    n_chk++; if (lsd_k != 3) begin n_fail++; $display("FAIL arb_ls_first: got ls_done cycle %0d, expected 3", lsd_k); end
    n_chk++; if (lsdata !== 32'h0000_00A5) begin n_fail++; $display("FAIL arb_ls_zext: got %h, expected 000000a5", lsdata); end
    n_chk++; if (first_if != 5) begin n_fail++; $display("FAIL arb_if_start: got cycle %0d, expected 5", first_if); end
    // Bubble cycle after ls_done, then a full 6-cycle fetch.
    n_chk++; if (ifd_k != lsd_k + 7) begin n_fail++; $display("FAIL arb_if_done: got cycle %0d, expected %0d", ifd_k, lsd_k + 7); end
    n_chk++; if (ifdata !== 32'h4433_2211) begin n_fail++; $display("FAIL arb_if_data: got %h, expected 44332211", ifdata); end
    n_chk++; if (nls != 1 || nif != 1) begin n_fail++; $display("FAIL arb_pulses: got ls=%0d if=%0d, expected 1/1", nls, nif); end
  endtask

  task automatic test_store();
    int nwr = 0, done_k = -1, ndone = 0;
    logic bad = 1'b0;
    logic [31:0] wd = 32'hDEAD_BEEF;
    ls_req_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h40; ls_wdata = wd; #1;
    for (int k = 1; k <= 7; k++) begin
      cyc(); ls_req_valid = 1'b0; #1;
      if (mem_wr === 1'b1) begin
        nwr++;
        if (k > 4) bad = 1'b1;
        else if (mem_a !== 32'h40 + 32'(k - 1) || mem_dout !== wd[8*(k-1) +: 8]) bad = 1'b1;
      end
      if (ls_done === 1'b1) begin ndone++; if (done_k < 0) done_k = k; end
    end
    n_chk++; if (nwr != 4) begin n_fail++; $display("FAIL store_wr_count: got %0d, expected 4", nwr); end
    n_chk++; if (bad) begin n_fail++; $display("FAIL store_bytes: got bad=%b, expected EF,BE,AD,DE at 0x40..0x43", bad); end
    n_chk++; if (done_k != 5 || ndone != 1) begin n_fail++; $display("FAIL store_done: got cycle %0d x%0d, expected cycle 5 x1", done_k, ndone); end
  endtask

  task automatic test_stall();
    int done_k = -1, ndone = 0;
    logic [31:0] got = '0;
    logic bad = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h100; #1;
    for (int k = 1; k <= 12; k++) begin
      cyc(); if_req_valid = 1'b0; rdy_in = !(k >= 3 && k <= 5); #1;
      if (k >= 3 && k <= 5 && (mem_a !== 32'h101 || mem_wr !== 1'b0)) bad = 1'b1;
      if (if_done === 1'b1) begin
        ndone++;
        if (done_k < 0) begin done_k = k; got = if_data; end
      end
    end
    rdy_in = 1'b1;
    n_chk++; if (bad) begin n_fail++; $display("FAIL stall_addr: got bad=%b, expected a=0x101 wr=0", bad); end
    n_chk++; if (done_k != 9 || ndone != 1) begin n_fail++; $display("FAIL stall_done: got cycle %0d x%0d, expected cycle 9 x1", done_k, ndone); end
    n_chk++; if (got !== 32'h0000_0513) begin n_fail++; $display("FAIL stall_data: got %h, expected 00000513", got); end
  endtask

  task automatic test_flush();
    int done_k = -1, ndone = 0;
    logic [31:0] got = '0;
    logic bad = 1'b0;
    if_req_valid = 1'b1; if_addr = 32'h100; #1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 1) if_req_valid = 1'b0;
      if (k == 4) if_flush = 1'b1;
      if (k == 5) begin if_flush = 1'b0; if_req_valid = 1'b1; if_addr = 32'h200; end
      if (k == 6) if_req_valid = 1'b0;
      #1;
      if (k == 4 && mem_a !== 32'h103) bad = 1'b1;
      if (k == 5 && mem_a !== 32'd0) bad = 1'b1;
      if (if_done === 1'b1) begin
        ndone++;
        if (done_k < 0) begin done_k = k; got = if_data; end
      end
    end
    n_chk++; if (bad) begin n_fail++; $display("FAIL flush_idle: got bad=%b, expected cnt3 then IDLE", bad); end
    n_chk++; if (done_k != 11 || ndone != 1) begin n_fail++; $display("FAIL flush_done: got cycle %0d x%0d, expected cycle 11 x1", done_k, ndone); end
    n_chk++; if (got !== 32'h4433_2211) begin n_fail++; $display("FAIL flush_refetch: got %h, expected 44332211", got); end
  endtask

  task automatic test_io_store();
    int nwr = 0, wr_k = -1, done_k = -1;
    logic bad = 1'b0;
    ls_req_valid = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000;
    ls_wdata = 32'h1234_565A; io_buffer_full = 1'b1; #1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) ls_req_valid = 1'b0;
      if (k == 6) io_buffer_full = 1'b0;
      #1;
      if (mem_wr === 1'b1) begin
        nwr++; wr_k = k;
        if (mem_a !== 32'h0003_0000 || mem_dout !== 8'h5A) bad = 1'b1;
      end
      if (ls_done === 1'b1 && done_k < 0) done_k = k;
    end
    n_chk++; if (nwr != 1 || wr_k != 6) begin n_fail++; $display("FAIL io_hold: got %0d writes last at %0d, expected 1 at 6", nwr, wr_k); end
    n_chk++; if (bad) begin n_fail++; $display("FAIL io_write: got bad=%b, expected 5a at 00030000", bad); end
    n_chk++; if (done_k != 7) begin n_fail++; $display("FAIL io_done: got cycle %0d, expected 7", done_k); end
  endtask

  task automatic test_wrap();
    int done_k = -1;
    logic [31:0] got = '0;
    logic bad = 1'b0;
    ls_req_valid = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'hFFFF_FFFF; #1;
    for (int k = 1; k <= 6; k++) begin
      cyc(); ls_req_valid = 1'b0; #1;
      if (k == 1 && mem_a !== 32'hFFFF_FFFF) bad = 1'b1;
      if (k == 2 && mem_a !== 32'h0000_0000) bad = 1'b1;
      if (ls_done === 1'b1 && done_k < 0) begin done_k = k; got = ls_rdata; end
    end
    n_chk++; if (bad) begin n_fail++; $display("FAIL wrap_addr: got bad=%b, expected ffffffff then 0", bad); end
    n_chk++; if (done_k != 4 || got !== 32'h0000_1234) begin n_fail++; $display("FAIL wrap_load: got cycle %0d data %h, expected 4 / 00001234", done_k, got); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    if_req_valid = 1'b1; if_addr = 32'h100; #1;
    for (int k = 1; k <= 3; k++) begin cyc(); if_req_valid = 1'b0; #1; end
    rst_in = 1'b0; #1;
    n_chk++;
    if ({mem_a, if_data, if_done, mem_wr} !== '0) begin
      n_fail++; $display("FAIL async_reset: got a=%h data=%h done=%b wr=%b, expected zeros", mem_a, if_data, if_done, mem_wr);
    end
    cyc(); rst_in = 1'b1;
    for (int k = 0; k < 8; k++) begin cyc(); #1; if (if_done === 1'b1) ndone++; end
    n_chk++; if (ndone != 0) begin n_fail++; $display("FAIL reset_discard: got %0d if_done pulses, expected 0", ndone); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h200] = 8'h11; ram[12'h201] = 8'h22; ram[12'h202] = 8'h33; ram[12'h203] = 8'h44;
    ram[12'h020] = 8'hA5;
    ram[12'hFFF] = 8'h34; ram[12'h000] = 8'h12;
    rdy_in = 1'b1; if_req_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;
    test_reset();
    test_if_read();
    test_arbitration();
    test_store();
    test_stall();
    test_flush();
    test_io_store();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
